data_ram_resp: RTL

Data-memory responder at the far end of the load/store RAM interface driven by the MEM stage.
- Accepts one word-wide read or write request per handshake.
- Inserts a configurable number of wait states, performs the array access, then holds a response until it is consumed.
- Byte/halfword merging and extraction stay in the requester; this block always transfers full words.

---
 rtl/data_ram_resp.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/data_ram_resp.sv
// Word-wide data-memory responder: accepts one request per handshake, waits WAIT_CYCLES, accesses the array, holds the response until consumed.
// Optional access counters are enabled by defining DATA_RAM_STATS_EN.
module data_ram_resp #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  ready_o,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    input  logic                  ram_w_request_i,
    output logic                  rvalid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  err_o
`ifdef DATA_RAM_STATS_EN
    ,
    output logic [15:0]           rd_cnt_o,
    output logic [15:0]           wr_cnt_o,
    output logic [15:0]           err_cnt_o
`endif
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    inr_q, inr_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   word;
    logic                    in_range_in;
    logic [IDX_W-1:0]        idx_in;
    logic                    accept;

    logic                    access;
    logic [IDX_W-1:0]        acc_idx;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    acc_we;
    logic                    acc_inr;
    logic                    mem_we;

    assign offset      = ram_addr_i - BASE_ADDR;
    assign word        = offset >> 2;
    assign in_range_in = (ram_addr_i >= BASE_ADDR) && (word < DEPTH_A);
    assign idx_in      = word[IDX_W-1:0];

    assign ready_o = rst_i && (state_q == ST_IDLE);
    assign accept  = ready_o && req_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        inr_d     = inr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        access    = 1'b0;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_we    = we_q;
        acc_inr   = inr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d   = idx_in;
                    wdata_d = ram_data_i;
                    we_d    = ram_w_request_i;
                    inr_d   = in_range_in;
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: access on the accept edge using the live request.
                        access    = 1'b1;
                        acc_idx   = idx_in;
                        acc_wdata = ram_data_i;
                        acc_we    = ram_w_request_i;
                        acc_inr   = in_range_in;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    rvalid_d = 1'b0;
                    err_d    = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (access) begin
            state_d  = ST_RESP;
            rvalid_d = 1'b1;
            err_d    = !acc_inr;
            rdata_d  = (acc_inr && !acc_we) ? mem_q[acc_idx] : '0;
        end
    end

    // Reset gates the commit so an interrupted write never lands.
    assign mem_we = rst_i && access && acc_we && acc_inr;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            inr_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            inr_q    <= inr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign rvalid_o   = rvalid_q;
    assign ram_data_o = rdata_q;
    assign err_o      = err_q;

`ifdef DATA_RAM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (access) begin
            // Out-of-range transactions only count as errors.
            if (!acc_inr) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else if (acc_we) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt_o  = rd_cnt_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign err_cnt_o = err_cnt_q;
`endif

endmodule
